// File: rtl/ahb5_mem_slave.sv
// AHB5 subordinate backed by a word-organised memory, with configurable wait states,
// two-cycle ERROR responses for illegal transfers, and saturating transfer/error counters.
module ahb5_mem_slave #(
    parameter int unsigned MEM_WORDS   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [15:0] xfer_cnt,
    output logic [15:0] err_cnt,
    output logic [2:0]  o_dbg_state
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_wcnt, w_wcnt_next;
    logic [31:0] r_addr;
    logic        r_write;
    logic [2:0]  r_size;
    logic [15:0] r_xfer_cnt, r_err_cnt;
    logic [31:0] r_mem [MEM_WORDS];

    logic        w_accept, w_illegal, w_load, w_commit;
    logic [31:0] w_offset, w_off_q;
    logic [AW-1:0] w_idx;
    logic [3:0]  w_be;
    logic        w_unused;

    assign w_accept  = HSEL & HREADY & HTRANS[1];
    assign w_offset  = HADDR - BASE_ADDR;
    assign w_illegal = (HSIZE > 3'b010)
                     | ((HSIZE == 3'b001) & HADDR[0])
                     | ((HSIZE == 3'b010) & (HADDR[1:0] != 2'b00))
                     | ({1'b0, w_offset} >= MEM_BYTES);

    // Next state and bus response; a new accept is only honoured where HREADYOUT is high.
    always_comb begin
        w_next      = r_state;
        w_wcnt_next = r_wcnt;
        w_load      = 1'b0;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                HRESP  = (r_state == ST_ERR2);
                w_next = ST_IDLE;
                if (w_accept) begin
                    w_load = 1'b1;
                    if (w_illegal) begin
                        w_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        w_next      = ST_WAIT;
                        w_wcnt_next = WS_LOAD;
                    end else begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (r_wcnt == 4'd0) w_next = ST_DONE;
                else                w_wcnt_next = r_wcnt - 4'd1;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                w_next    = ST_ERR2;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 4'd0;
            r_addr  <= 32'd0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_next;
            if (w_load) begin
                r_addr  <= HADDR;
                r_write <= HWRITE;
                r_size  <= HSIZE;
            end
        end
    end

    assign w_off_q = r_addr - BASE_ADDR;
    assign w_idx   = w_off_q[AW+1:2];

    always_comb begin
        w_be = 4'b1111;
        case (r_size)
            3'b000:  w_be = 4'b0001 << w_off_q[1:0];
            3'b001:  w_be = w_off_q[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    // Only legal transfers ever reach DONE, so erroring writes never touch memory.
    assign w_commit = (r_state == ST_DONE) & r_write;

    always_ff @(posedge HCLK) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HRDATA = (r_state == ST_DONE) ? r_mem[w_idx] : 32'd0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_xfer_cnt <= 16'd0;
            r_err_cnt  <= 16'd0;
        end else begin
            if ((r_state == ST_DONE) && (r_xfer_cnt != 16'hFFFF)) r_xfer_cnt <= r_xfer_cnt + 16'd1;
            if ((r_state == ST_ERR2) && (r_err_cnt != 16'hFFFF))  r_err_cnt  <= r_err_cnt + 16'd1;
        end
    end

    assign xfer_cnt    = r_xfer_cnt;
    assign err_cnt     = r_err_cnt;
    assign o_dbg_state = r_state;
    assign w_unused    = ^{HBURST, HPROT, HTRANS[0], w_off_q[31:AW+2]};

endmodule

// File: tb/tb_ahb5_mem_slave.sv
// Scoreboard bench: two subordinates (one wait state, zero wait states) share one driven bus,
// a reference model predicts each response and a negedge monitor checks every data phase.
module tb_ahb5_mem_slave;

    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_4000;
    localparam int          WORDS = 256;

    logic        clk, rst_n;
    logic        sel;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;

    logic        rdy0, rdy1, resp0, resp1;
    logic [31:0] rd0, rd1;
    logic [15:0] xc0, xc1, ec0, ec1;
    logic [2:0]  dbg0, dbg1;

    logic        b_ready, b_resp;
    logic [31:0] b_rdata;
    logic [15:0] b_xfer, b_errc;

    assign b_ready = sel ? rdy1  : rdy0;
    assign b_resp  = sel ? resp1 : resp0;
    assign b_rdata = sel ? rd1   : rd0;
    assign b_xfer  = sel ? xc1   : xc0;
    assign b_errc  = sel ? ec1   : ec0;

    ahb5_mem_slave #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE0), .WAIT_STATES(1)) u_dut0 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & ~sel), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HWDATA(hwdata),
        .HREADY(rdy0), .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0),
        .xfer_cnt(xc0), .err_cnt(ec0), .o_dbg_state(dbg0)
    );

    ahb5_mem_slave #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE1), .WAIT_STATES(0)) u_dut1 (
        .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel & sel), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HTRANS(htrans), .HWDATA(hwdata),
        .HREADY(rdy1), .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rd1),
        .xfer_cnt(xc1), .err_cnt(ec1), .o_dbg_state(dbg1)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model and scoreboard: entry = {is_error, is_read, read_data}
    logic [31:0] m_mem [2][WORDS];
    int          m_xfer [2];
    int          m_err  [2];
    logic [33:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] base_of(input logic s);
        return s ? BASE1 : BASE0;
    endfunction

    function automatic void model_push(input logic w, input logic [31:0] a,
                                       input logic [2:0] sz, input logic [31:0] wd);
        logic [31:0] off;
        logic        bad;
        int          idx, nbytes, lane;
        off = a - base_of(sel);
        bad = (sz > 3'd2) || (off >= WORDS * 4);
        if (!bad) begin
            nbytes = 1 << sz;
            bad = (a % nbytes) != 0;
        end
        if (bad) begin
            exp_q.push_back({1'b1, ~w, 32'd0});
        end else begin
            idx = int'(off / 4);
            if (w) begin
                for (int k = 0; k < nbytes; k++) begin
                    lane = int'(off % 4) + k;
                    m_mem[sel][idx][8*lane +: 8] = wd[8*lane +: 8];
                end
                exp_q.push_back({1'b0, 1'b0, 32'd0});
            end else begin
                exp_q.push_back({1'b0, 1'b1, m_mem[sel][idx]});
            end
        end
    endfunction

    // Driver: present one address phase just after a rising edge and hold it until HREADY
    task automatic drive_phase(input logic s, input logic w, input logic [31:0] a,
                               input logic [2:0] sz, input logic [1:0] tr, input logic [31:0] wd);
        logic rdy;
        int   n;
        hsel = s; hwrite = w; haddr = a; hsize = sz; htrans = tr;
        hburst = 3'($urandom); hprot = 4'($urandom);
        n = 0;
        forever begin
            @(negedge clk);
            rdy = b_ready;
            @(posedge clk);
            if (rdy) break;
            n++;
            if (n > 40) begin
                chk("hready_timeout", 32'(n), 32'd40);
                break;
            end
        end
        #1;
        if (s && tr[1]) begin
            model_push(w, a, sz, wd);
            hwdata = wd;
        end
        hsel = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic mon_pend = 1'b0;
    int   mon_low  = 0;

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || mon_pend) && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 50) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        idle_cycles(2);
    endtask

    // Monitor: one check per cycle, on the falling edge
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst_n) begin
            mon_pend = 1'b0;
            mon_low  = 0;
            exp_q.delete();
            m_xfer = '{0, 0};
            m_err  = '{0, 0};
        end else begin
            if (mon_pend) begin
                if (exp_q.size() == 0) begin
                    chk("queue_empty", 32'd1, 32'd0);
                    mon_pend = 1'b0;
                end else begin
                    e = exp_q[0];
                    if (!b_ready) begin
                        mon_low++;
                        chk("wait_resp", 32'(b_resp), 32'(e[33]));
                        chk("wait_rdata", b_rdata, 32'd0);
                        if (mon_low > 20) begin
                            chk("wait_timeout", 32'(mon_low), 32'd20);
                            void'(exp_q.pop_front());
                            mon_pend = 1'b0;
                        end
                    end else begin
                        void'(exp_q.pop_front());
                        chk("low_cycles", 32'(mon_low), e[33] ? 32'd1 : (sel ? 32'd0 : 32'd1));
                        chk("resp", 32'(b_resp), 32'(e[33]));
                        if (e[33])      chk("err_rdata", b_rdata, 32'd0);
                        else if (e[32]) chk("rdata", b_rdata, e[31:0]);
                        chk("xfer_cnt", 32'(b_xfer), 32'(m_xfer[sel]));
                        chk("err_cnt", 32'(b_errc), 32'(m_err[sel]));
                        if (e[33]) m_err[sel]  = (m_err[sel]  < 65535) ? m_err[sel] + 1  : 65535;
                        else       m_xfer[sel] = (m_xfer[sel] < 65535) ? m_xfer[sel] + 1 : 65535;
                        mon_pend = 1'b0;
                    end
                end
            end else begin
                chk("idle_ready", 32'(b_ready), 32'd1);
                chk("idle_resp", 32'(b_resp), 32'd0);
                chk("idle_rdata", b_rdata, 32'd0);
            end
            if (b_ready && hsel && htrans[1]) begin
                mon_pend = 1'b1;
                mon_low  = 0;
            end
        end
    end

    task automatic random_xfers(input int n);
        logic        s, w;
        logic [1:0]  tr;
        logic [2:0]  sz;
        logic [31:0] a, b, msk;
        int          r;
        b = base_of(sel);
        for (int i = 0; i < n; i++) begin
            s  = ($urandom_range(0, 9) != 0);
            tr = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            w  = 1'($urandom);
            r  = $urandom_range(0, 11);
            sz = (r >= 10) ? 3'($urandom_range(3, 7)) : 3'(r % 3);
            r  = $urandom_range(0, 15);
            if (r == 0)      a = $urandom();
            else if (r == 1) a = b + WORDS * 4 + 32'($urandom_range(0, 63));
            else if (r == 2) a = b - 32'd4;
            else             a = b + 32'($urandom_range(0, WORDS * 4 - 1));
            if (r >= 3 && $urandom_range(0, 3) != 0 && sz <= 3'd2) begin
                msk = (32'd1 << sz) - 32'd1;
                a = a & ~msk;
            end
            drive_phase(s, w, a, sz, tr, $urandom());
        end
    endtask

    logic [31:0] saved;

    initial begin
        rst_n = 1'b0; sel = 1'b0; hsel = 1'b0; hwrite = 1'b0; haddr = '0; hwdata = '0;
        hsize = '0; hburst = '0; hprot = '0; htrans = 2'b00;
        m_xfer = '{0, 0};
        m_err  = '{0, 0};
        #22;
        chk("rst_hreadyout", 32'(rdy0), 32'd1);
        chk("rst_hresp", 32'(resp0), 32'd0);
        chk("rst_hrdata", rd0, 32'd0);
        chk("rst_xfer_cnt", 32'(xc0), 32'd0);
        chk("rst_err_cnt", 32'(ec0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One wait state: word write then read back
        drive_phase(1, 1, 32'h10, 3'd2, 2'b10, 32'hDEAD_BEEF);
        drive_phase(1, 0, 32'h10, 3'd2, 2'b10, 32'h0);
        drain();
        chk("t1_xfer_cnt", 32'(xc0), 32'd2);

        // Byte write into a known word
        drive_phase(1, 1, 32'h10, 3'd2, 2'b10, 32'h1122_3344);
        drive_phase(1, 1, 32'h13, 3'd0, 2'b10, 32'hAA00_0000);
        drive_phase(1, 0, 32'h10, 3'd2, 2'b10, 32'h0);
        drain();
        chk("t2_read_word", m_mem[0][4], 32'hAA22_3344);

        // Misaligned word read
        drive_phase(1, 0, 32'h02, 3'd2, 2'b10, 32'h0);
        drain();
        chk("t3_err_cnt", 32'(ec0), 32'd1);

        // Oversize transfer and out-of-range write must leave word 0 alone
        drive_phase(1, 1, 32'h0, 3'd2, 2'b10, 32'h0BAD_F00D);
        drive_phase(1, 1, 32'h0, 3'd3, 2'b10, 32'hFFFF_FFFF);
        drive_phase(1, 1, BASE0 + WORDS * 4, 3'd2, 2'b10, 32'h1234_5678);
        drive_phase(1, 0, 32'h0, 3'd2, 2'b10, 32'h0);
        drain();
        chk("t4_err_cnt", 32'(ec0), 32'd3);

        // Zero wait states: back-to-back write then read of the same word
        sel = 1'b1;
        drive_phase(1, 1, BASE1 + 32'h20, 3'd2, 2'b10, 32'h5);
        drive_phase(1, 0, BASE1 + 32'h20, 3'd2, 2'b11, 32'h0);
        drain();

        // Give every word a known value in both memories
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int i = 0; i < WORDS; i++)
                drive_phase(1, 1, base_of(sel) + 32'(4 * i), 3'd2, 2'b10, $urandom());
            drain();
        end

        // Reset in the wait state of a write drops the write
        sel = 1'b0;
        saved = m_mem[0][16];
        drive_phase(1, 1, 32'h40, 3'd2, 2'b10, ~saved);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_hreadyout", 32'(rdy0), 32'd1);
        chk("t6_async_hresp", 32'(resp0), 32'd0);
        m_mem[0][16] = saved;
        @(negedge clk);
        #1;
        chk("t6_xfer_cnt", 32'(xc0), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_phase(1, 0, 32'h40, 3'd2, 2'b10, 32'h0);
        drain();

        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            random_xfers(3000);
            drain();
            chk("final_xfer_cnt", 32'(b_xfer), 32'(m_xfer[sel]));
            chk("final_err_cnt", 32'(b_errc), 32'(m_err[sel]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
